idu_compute_instr_queue: RTL and testbench



---
 rtl/idu_cq_pkg.sv | 25 ++
 rtl/idu_cq_mem.sv | 27 ++
 rtl/idu_compute_instr_queue.sv | 141 ++++++++++++++
 tb/tb_idu_compute_instr_queue.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/idu_cq_pkg.sv
// Shared constants and types for the IDU compute-instruction queue.
// Instruction layout is four equal fields: opcode, then A, B and C start addresses.
package idu_cq_pkg;

   localparam int FIFO_WIDTH_DEF  = 16;
   localparam int INSTR_WIDTH_DEF = 4 * FIFO_WIDTH_DEF;

   // Field positions, counted in units of one field width from the LSB.
   localparam int OPC_FIELD    = 0;
   localparam int ADDR_A_FIELD = 1;
   localparam int ADDR_B_FIELD = 2;
   localparam int ADDR_C_FIELD = 3;

   localparam logic [FIFO_WIDTH_DEF-1:0] OPC_COMPUTE = 16'h00C1;

   typedef enum logic {
      RSP_IDLE,
      RSP_DONE
   } rsp_state_e;

   function automatic int fieldLsb(input int field, input int fieldWidth);
      return field * fieldWidth;
   endfunction

endpackage

// File: rtl/idu_cq_mem.sv
// Register-array storage for the compute-instruction queue.
// Writes land on the clock edge; the head entry is read combinationally.
module idu_cq_mem #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 64,
   localparam int PW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             wr_en_i,
   input  logic [PW-1:0]    wr_ptr_i,
   input  logic [WIDTH-1:0] wr_data_i,
   input  logic [PW-1:0]    rd_ptr_i,
   output logic [WIDTH-1:0] rd_data_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   // Storage is not reset: occupancy is tracked by the pointers and count.
   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         mem_q[wr_ptr_i] <= wr_data_i;
      end
   end

   assign rd_data_o = mem_q[rd_ptr_i];

endmodule

// File: rtl/idu_compute_instr_queue.sv
// IDU-side compute-instruction queue answering DFU fetch requests, one pop per request.
// Optional opcode screening of pushes is enabled with `define IDU_CQ_OPCODE_CHECK_EN.
module idu_compute_instr_queue
   import idu_cq_pkg::*;
#(
   parameter int FIFO_WIDTH  = FIFO_WIDTH_DEF,
   parameter int INSTR_WIDTH = INSTR_WIDTH_DEF,
   parameter int DEPTH       = 8,
   localparam int PW         = $clog2(DEPTH),
   localparam int CW         = $clog2(DEPTH) + 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [INSTR_WIDTH-1:0] dec2cq_instr,
   input  logic                   dec2cq_instr_wr_en,
   output logic                   cq2dec_full,
   output logic                   cq2dec_overflow,
   output logic                   cq2dec_err,
   output logic [CW-1:0]          cq_count,
   output logic                   idu2dfu_compute_fifo_empty,
   input  logic                   dfu2idu_compute_instr_req,
   output logic [INSTR_WIDTH-1:0] idu2dfu_compute_instr,
   output logic                   idu2dfu_compute_instr_vld
);

   if (INSTR_WIDTH != 4 * FIFO_WIDTH) begin : gBadWidth
      $error("INSTR_WIDTH must be four FIFO_WIDTH fields");
   end

   rsp_state_e             state_q, state_d;
   logic [PW-1:0]          wrPtr_q, wrPtr_d;
   logic [PW-1:0]          rdPtr_q, rdPtr_d;
   logic [CW-1:0]          count_q, count_d;
   logic [INSTR_WIDTH-1:0] rspInstr_q, rspInstr_d;
   logic                   rspVld_q, rspVld_d;
   logic                   overflow_q, overflow_d;
   logic                   opcBad;
   logic                   isFull;
   logic                   pushOk;
   logic                   pushDrop;
   logic                   popEn;
   logic [INSTR_WIDTH-1:0] headData;

   idu_cq_mem #(
      .DEPTH (DEPTH),
      .WIDTH (INSTR_WIDTH)
   ) uMem (
      .clk       (clk),
      .wr_en_i   (pushOk),
      .wr_ptr_i  (wrPtr_q),
      .wr_data_i (dec2cq_instr),
      .rd_ptr_i  (rdPtr_q),
      .rd_data_o (headData)
   );

`ifdef IDU_CQ_OPCODE_CHECK_EN
   logic err_q;

   // Opcode is screened before fullness so a bad push into a full queue reports err only.
   assign opcBad = dec2cq_instr_wr_en &&
                   (dec2cq_instr[fieldLsb(OPC_FIELD, FIFO_WIDTH) +: FIFO_WIDTH]
                    != FIFO_WIDTH'(OPC_COMPUTE));

   always_ff @(posedge clk) begin
      if (rst) begin
         err_q <= 1'b0;
      end else begin
         err_q <= opcBad;
      end
   end

   assign cq2dec_err = err_q;
`else
   assign opcBad     = 1'b0;
   assign cq2dec_err = 1'b0;
`endif

   // Fullness is judged on the pre-edge count, so a same-cycle pop never frees room for a push.
   always_comb begin
      isFull   = (count_q == CW'(DEPTH));
      pushOk   = dec2cq_instr_wr_en && !opcBad && !isFull;
      pushDrop = dec2cq_instr_wr_en && !opcBad && isFull;
   end

   // The request is a level held past the valid pulse, so RSP_DONE absorbs it until it drops.
   always_comb begin
      state_d = state_q;
      popEn   = 1'b0;
      case (state_q)
         RSP_IDLE: begin
            if (dfu2idu_compute_instr_req && (count_q != '0)) begin
               popEn   = 1'b1;
               state_d = RSP_DONE;
            end
         end
         RSP_DONE: begin
            if (!dfu2idu_compute_instr_req) begin
               state_d = RSP_IDLE;
            end
         end
         default: state_d = RSP_IDLE;
      endcase
   end

   always_comb begin
      wrPtr_d    = wrPtr_q + PW'(pushOk);
      rdPtr_d    = rdPtr_q + PW'(popEn);
      count_d    = count_q + CW'(pushOk) - CW'(popEn);
      rspInstr_d = popEn ? headData : rspInstr_q;
      rspVld_d   = popEn;
      overflow_d = pushDrop;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= RSP_IDLE;
         wrPtr_q    <= '0;
         rdPtr_q    <= '0;
         count_q    <= '0;
         rspInstr_q <= '0;
         rspVld_q   <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         wrPtr_q    <= wrPtr_d;
         rdPtr_q    <= rdPtr_d;
         count_q    <= count_d;
         rspInstr_q <= rspInstr_d;
         rspVld_q   <= rspVld_d;
         overflow_q <= overflow_d;
      end
   end

   assign cq2dec_full                = (count_q == CW'(DEPTH));
   assign idu2dfu_compute_fifo_empty = (count_q == '0);
   assign cq_count                   = count_q;
   assign cq2dec_overflow            = overflow_q;
   assign idu2dfu_compute_instr      = rspInstr_q;
   assign idu2dfu_compute_instr_vld  = rspVld_q;

endmodule

// File: tb/tb_idu_compute_instr_queue.sv
// Bench for idu_compute_instr_queue: queue-based reference model, directed scenarios, random traffic.
module tb_idu_compute_instr_queue;
   import idu_cq_pkg::*;

   localparam int FW    = 16;
   localparam int IW    = 64;
   localparam int DEPTH = 8;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst;
   logic [IW-1:0] instrIn;
   logic          wrEn;
   logic          reqIn;
   logic          full;
   logic          overflow;
   logic          err;
   logic [CW-1:0] count;
   logic          empty;
   logic [IW-1:0] rspInstr;
   logic          rspVld;

   always #5 clk = ~clk;

   idu_compute_instr_queue #(
      .FIFO_WIDTH  (FW),
      .INSTR_WIDTH (IW),
      .DEPTH       (DEPTH)
   ) dut (
      .clk                        (clk),
      .rst                        (rst),
      .dec2cq_instr               (instrIn),
      .dec2cq_instr_wr_en         (wrEn),
      .cq2dec_full                (full),
      .cq2dec_overflow            (overflow),
      .cq2dec_err                 (err),
      .cq_count                   (count),
      .idu2dfu_compute_fifo_empty (empty),
      .dfu2idu_compute_instr_req  (reqIn),
      .idu2dfu_compute_instr      (rspInstr),
      .idu2dfu_compute_instr_vld  (rspVld)
   );

   // Reference model: a plain FIFO plus a flag saying the current request was already served.
   logic [IW-1:0] mq[$];
   bit            mServed  = 1'b0;
   bit            expVld   = 1'b0;
   bit            expOvf   = 1'b0;
   bit            expErr   = 1'b0;
   logic [IW-1:0] expInstr = '0;
   bit            mBad, mFull, mPop;

   always @(posedge clk) begin
      if (rst) begin
         mq.delete();
         mServed  = 1'b0;
         expVld   = 1'b0;
         expOvf   = 1'b0;
         expErr   = 1'b0;
         expInstr = '0;
      end else begin
`ifdef IDU_CQ_OPCODE_CHECK_EN
         mBad = wrEn && (instrIn[FW-1:0] != OPC_COMPUTE);
`else
         mBad = 1'b0;
`endif
         mFull  = (mq.size() == DEPTH);
         mPop   = !mServed && reqIn && (mq.size() > 0);
         expOvf = wrEn && !mBad && mFull;
         expErr = mBad;
         if (mServed && !reqIn) mServed = 1'b0;
         expVld = mPop;
         if (mPop) begin
            expInstr = mq.pop_front();
            mServed  = 1'b1;
         end
         if (wrEn && !mBad && !mFull) mq.push_back(instrIn);
      end
   end

   int checks = 0;
   int passes = 0;
   bit cmpEn  = 1'b0;
   bit lastVld = 1'b0;

   task automatic checkOutput(input string name, input logic [IW-1:0] act, input logic [IW-1:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   always @(negedge clk) begin
      lastVld = expVld;
      if (cmpEn) begin
         checkOutput("full",     IW'(full),     IW'(mq.size() == DEPTH));
         checkOutput("empty",    IW'(empty),    IW'(mq.size() == 0));
         checkOutput("count",    IW'(count),    IW'(mq.size()));
         checkOutput("overflow", IW'(overflow), IW'(expOvf));
         checkOutput("err",      IW'(err),      IW'(expErr));
         checkOutput("vld",      IW'(rspVld),   IW'(expVld));
         checkOutput("instr",    rspInstr,      expInstr);
      end
   end

   function automatic logic [IW-1:0] mkInstr(input logic [15:0] c, input logic [15:0] b,
                                             input logic [15:0] a, input logic [15:0] op);
      return {c, b, a, op};
   endfunction

   function automatic logic [IW-1:0] entry(input int i);
      return mkInstr(16'h3000 + 16'(i), 16'h2000 + 16'(i), 16'h1000 + 16'(i), OPC_COMPUTE);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic w, input logic [IW-1:0] d, input logic r);
      wrEn    = w;
      instrIn = d;
      reqIn   = r;
   endtask

   task automatic doReset();
      rst = 1'b1;
      applyStimulus(1'b0, '0, 1'b0);
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic pushOne(input logic [IW-1:0] d);
      applyStimulus(1'b1, d, reqIn);
      tick();
      wrEn = 1'b0;
   endtask

   // Behaves like the DFU: hold req until valid is seen, drop it the following cycle.
   task automatic requestOne(output logic [IW-1:0] got);
      bit seen = 1'b0;
      got   = '0;
      reqIn = 1'b1;
      for (int k = 0; k < 20 && !seen; k++) begin
         @(negedge clk);
         if (rspVld === 1'b1) begin
            seen = 1'b1;
            got  = rspInstr;
         end
      end
      if (!seen) checkOutput("req_timeout", IW'(0), IW'(1));
      tick();
      reqIn = 1'b0;
      tick();
   endtask

   logic [IW-1:0] got;
   int            waitCycles;

   initial begin
      rst = 1'b1;
      applyStimulus(1'b0, '0, 1'b0);
      doReset();
      cmpEn = 1'b1;

      @(negedge clk);
      checkOutput("reset_empty", IW'(empty), IW'(1));
      checkOutput("reset_count", IW'(count), IW'(0));
      checkOutput("reset_instr", rspInstr, IW'(0));
      tick();

      // Single push and one two-cycle request.
      pushOne(mkInstr(16'h0300, 16'h0200, 16'h0100, OPC_COMPUTE));
      @(negedge clk);
      checkOutput("push_empty_fall", IW'(empty), IW'(0));
      checkOutput("push_count",      IW'(count), IW'(1));
      reqIn = 1'b1;
      tick();
      @(negedge clk);
      checkOutput("rsp1_vld",   IW'(rspVld), IW'(1));
      checkOutput("rsp1_instr", rspInstr,    64'h0300_0200_0100_00C1);
      checkOutput("rsp1_count", IW'(count),  IW'(0));
      tick();
      reqIn = 1'b0;
      @(negedge clk);
      checkOutput("rsp1_vld_once", IW'(rspVld), IW'(0));
      tick();

      // Fill, overflow, drain in order across the pointer wrap.
      for (int i = 0; i < DEPTH; i++) pushOne(entry(i));
      pushOne(entry(DEPTH));
      @(negedge clk);
      checkOutput("ovf_pulse", IW'(overflow), IW'(1));
      checkOutput("ovf_count", IW'(count),    IW'(8));
      checkOutput("ovf_full",  IW'(full),     IW'(1));
      @(negedge clk);
      checkOutput("ovf_single", IW'(overflow), IW'(0));
      tick();
      for (int i = 0; i < DEPTH; i++) begin
         requestOne(got);
         checkOutput($sformatf("drain%0d", i), got, entry(i));
      end

      // Request into an empty queue, push three cycles later.
      reqIn = 1'b1;
      tick();
      tick();
      tick();
      pushOne(entry(20));
      waitCycles = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         waitCycles++;
         if (rspVld === 1'b1) break;
      end
      checkOutput("late_push_latency", IW'(waitCycles), IW'(2));
      checkOutput("late_push_instr",   rspInstr,        entry(20));
      tick();
      reqIn = 1'b0;
      tick();

      // Simultaneous push and pop at count 4.
      for (int i = 0; i < 4; i++) pushOne(entry(30 + i));
      applyStimulus(1'b1, entry(34), 1'b1);
      tick();
      wrEn = 1'b0;
      @(negedge clk);
      checkOutput("simul_count", IW'(count), IW'(4));
      checkOutput("simul_instr", rspInstr,   entry(30));
      tick();
      reqIn = 1'b0;
      tick();
      for (int i = 1; i < 5; i++) begin
         requestOne(got);
         checkOutput($sformatf("simul_order%0d", i), got, entry(30 + i));
      end

      // Reset lands in the cycle after a request was accepted.
      pushOne(entry(40));
      pushOne(entry(41));
      reqIn = 1'b1;
      tick();
      rst = 1'b1;
      tick();
      rst   = 1'b0;
      reqIn = 1'b0;
      @(negedge clk);
      checkOutput("rst_mid_vld",   IW'(rspVld), IW'(0));
      checkOutput("rst_mid_empty", IW'(empty),  IW'(1));
      checkOutput("rst_mid_count", IW'(count),  IW'(0));
      tick();
      pushOne(entry(42));
      requestOne(got);
      checkOutput("after_rst_instr", got, entry(42));

      // Push with a non-compute opcode.
      doReset();
      pushOne(mkInstr(16'h0003, 16'h0002, 16'h0001, OPC_COMPUTE + 16'd1));
      @(negedge clk);
`ifdef IDU_CQ_OPCODE_CHECK_EN
      checkOutput("badopc_err",   IW'(err),   IW'(1));
      checkOutput("badopc_count", IW'(count), IW'(0));
`else
      checkOutput("badopc_err",   IW'(err),   IW'(0));
      checkOutput("badopc_count", IW'(count), IW'(1));
`endif
      tick();

      // Random traffic with an occasional reset.
      for (int cyc = 0; cyc < 3000; cyc++) begin
         rst     = ($urandom_range(0, 299) == 0);
         wrEn    = ($urandom_range(0, 99) < 45);
         instrIn = {$urandom, $urandom};
         if ($urandom_range(0, 9) != 0) instrIn[FW-1:0] = OPC_COMPUTE;
         if (lastVld) reqIn = 1'b0;
         else if (!reqIn && $urandom_range(0, 2) == 0) reqIn = 1'b1;
         tick();
      end
      rst = 1'b0;
      applyStimulus(1'b0, '0, 1'b0);
      tick();
      @(negedge clk);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
